// File: rtl/byteswap_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one byteswap swapper from
// C_NUM_STREAMS AXI4-Stream sources; a grant is held from first beat to tlast.
// Ports:
//   s_axis_aclk / s_axis_areset : clock, synchronous active-high reset
//   ctrl_mask                   : per-stream enable, sampled only while idle
//   s_axis_*                    : N packed source streams (stream i at slice i)
//   m_axis_*                    : registered muxed stream, tid = source index
//   pkt_count                   : packets completed on the input side (wraps)
module byteswap_stream_arbiter #(
  parameter int C_NUM_STREAMS      = 4,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ID_WIDTH         = 2
) (
  input  logic                                      s_axis_aclk,
  input  logic                                      s_axis_areset,
  input  logic [C_NUM_STREAMS-1:0]                  ctrl_mask,
  input  logic [C_NUM_STREAMS-1:0]                  s_axis_tvalid,
  output logic [C_NUM_STREAMS-1:0]                  s_axis_tready,
  input  logic [C_NUM_STREAMS*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_STREAMS*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_STREAMS-1:0]                  s_axis_tlast,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                                      m_axis_tlast,
  output logic [C_ID_WIDTH-1:0]                     m_axis_tid,
  output logic [31:0]                               pkt_count
);

  localparam int N = C_NUM_STREAMS;
  localparam int W = C_AXIS_TDATA_WIDTH;
  localparam int K = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [C_ID_WIDTH-1:0] grant;
  logic [C_ID_WIDTH-1:0] grant_nxt;
  logic [C_ID_WIDTH-1:0] last_grant;
  logic [C_ID_WIDTH-1:0] last_grant_nxt;
  logic [C_ID_WIDTH-1:0] pick;
  logic                  found;
  logic [N-1:0]          req;
  logic                  out_ready;
  logic                  accept;
  logic                  beat_last;

  assign out_ready = m_axis_tready | ~m_axis_tvalid;
  assign req       = s_axis_tvalid & ctrl_mask;
  assign beat_last = s_axis_tlast[grant];
  assign accept    = (state == LOCKED)
                   & s_axis_tvalid[grant]
                   & out_ready;

  // Search starts just past the previous winner and wraps at N.
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = C_ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (state == LOCKED)
      s_axis_tready[grant] = out_ready;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && beat_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= C_ID_WIDTH'(N - 1);
      m_axis_tvalid <= 1'b0;
      pkt_count     <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      if (out_ready)
        m_axis_tvalid <= accept;
      if (accept && beat_last)
        pkt_count <= pkt_count + 32'd1;
    end
  end

  // Payload needs no reset: it is only meaningful while tvalid is high.
  always_ff @(posedge s_axis_aclk) begin
    if (accept) begin
      m_axis_tdata <= s_axis_tdata[grant*W +: W];
      m_axis_tkeep <= s_axis_tkeep[grant*K +: K];
      m_axis_tlast <= beat_last;
      m_axis_tid   <= grant;
    end
  end

endmodule

// File: tb/tb_byteswap_stream_arbiter.sv
// Bench for byteswap_stream_arbiter: packet queues per source, a
// packet-level round-robin scoreboard and directed literal checks.
module tb_byteswap_stream_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int K = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   mask;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tready;
  logic [N*W-1:0] s_tdata;
  logic [N*K-1:0] s_tkeep;
  logic [N-1:0]   s_tlast;
  logic           m_tvalid;
  logic           m_tready;
  logic [W-1:0]   m_tdata;
  logic [K-1:0]   m_tkeep;
  logic           m_tlast;
  logic [1:0]     m_tid;
  logic [31:0]    pkt_count;

  byteswap_stream_arbiter #(
    .C_NUM_STREAMS     (N),
    .C_AXIS_TDATA_WIDTH(W),
    .C_ID_WIDTH        (2)
  ) dut (
    .s_axis_aclk  (clk),
    .s_axis_areset(rst),
    .ctrl_mask    (mask),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .m_axis_tid   (m_tid),
    .pkt_count    (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  beat_t drv_q[N][$];
  beat_t exp_q[N][$];
  int    starts[$];
  int    beats_seen = 0;
  logic [N-1:0] model_mask;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard state
  int         last_tid;
  bit         in_pkt;
  int         cur_tid;
  bit         hold;
  logic [38:0] held;
  int         mcount;

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last_tid + k) % N;
      if (exp_q[idx].size() > 0 && model_mask[idx])
        return idx;
    end
    return 15;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      last_tid = N - 1;
      in_pkt   = 0;
      hold     = 0;
      mcount   = 0;
    end else begin
      chk("pkt_count", 64'(pkt_count), 64'(mcount));
      chk("tready_onehot", 64'($countones(s_tready) <= 1), 64'd1);
      if (hold) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_data", 64'({m_tdata, m_tkeep, m_tlast, m_tid}),
            64'(held));
      end
      hold = m_tvalid && !m_tready;
      held = {m_tdata, m_tkeep, m_tlast, m_tid};
      if (m_tvalid && m_tready) begin
        if (!in_pkt) begin
          chk("rr_tid", 64'(m_tid), 64'(rr_pick()));
          starts.push_back(int'(m_tid));
          in_pkt  = 1;
          cur_tid = int'(m_tid);
        end else begin
          chk("pkt_tid", 64'(m_tid), 64'(cur_tid));
        end
        total++;
        if (exp_q[m_tid].size() == 0) begin
          bad++;
          $display("FAIL extra_beat tid=%0d data=%0h", m_tid, m_tdata);
        end else begin
          beat_t b;
          b = exp_q[m_tid].pop_front();
          if ({m_tdata, m_tkeep, m_tlast} !== b) begin
            bad++;
            $display("FAIL beat act=%0h exp=%0h",
                     {m_tdata, m_tkeep, m_tlast}, b);
          end
        end
        beats_seen++;
        if (m_tlast) begin
          in_pkt   = 0;
          last_tid = int'(m_tid);
        end
      end
      if (|(s_tvalid & s_tready & s_tlast))
        mcount++;
    end
  end

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (drv_q[i].size() > 0) begin
        beat_t b;
        b = drv_q[i][0];
        s_tvalid[i]        = 1'b1;
        s_tdata[i*W +: W]  = b.data;
        s_tkeep[i*K +: K]  = b.keep;
        s_tlast[i]         = b.last;
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tdata[i*W +: W]  = '0;
        s_tkeep[i*K +: K]  = '0;
        s_tlast[i]         = 1'b0;
      end
    end
  endtask

  task automatic load_pkt(input int s, input int p, input int len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.data = {8'(s), 8'(p), 8'(b), 8'h5A};
      x.keep = (b == len - 1) ? 4'b0011 : 4'hF;
      x.last = (b == len - 1);
      drv_q[s].push_back(x);
      exp_q[s].push_back(x);
    end
  endtask

  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) void'(drv_q[i].pop_front());
    refresh();
    #1;
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++)
      if (exp_q[i].size() > 0) return 1;
    return m_tvalid;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    total++;
    if (busy()) begin
      bad++;
      $display("FAIL drain_timeout act=%0d exp=%0d", n, budget);
    end
  endtask

  task automatic do_reset(input int n, input bit all_valid);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    refresh();
    if (all_valid) s_tvalid = '1;
    repeat (n) begin
      @(posedge clk);
      #2;
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_mvalid", 64'(m_tvalid), 64'd0);
      chk("rst_cnt", 64'(pkt_count), 64'd0);
    end
    rst = 1'b0;
    refresh();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ss_d[4];
    int          rr_exp[5];
    int          mk_exp[8];
    int          s0;
    int          b0;
    ss_d   = '{32'h0200_005A, 32'h0200_015A,
               32'h0200_025A, 32'h0200_035A};
    rr_exp = '{0, 1, 2, 3, 0};
    mk_exp = '{1, 3, 1, 3, 0, 2, 0, 2};
    rst        = 1'b1;
    m_tready   = 1'b1;
    mask       = 4'hF;
    model_mask = 4'hF;
    s_tvalid   = '0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tlast    = '0;

    do_reset(3, 1'b1);

    // Single stream, 4 beats, first beat visible two cycles later
    load_pkt(2, 0, 4);
    refresh();
    #1;
    step();
    chk("ss_c1_valid", 64'(m_tvalid), 64'd0);
    step();
    for (int b = 0; b < 4; b++) begin
      chk("ss_valid", 64'(m_tvalid), 64'd1);
      chk("ss_data", 64'(m_tdata), 64'(ss_d[b]));
      chk("ss_tid", 64'(m_tid), 64'd2);
      chk("ss_last", 64'(m_tlast), 64'(b == 3));
      step();
    end
    chk("ss_end_valid", 64'(m_tvalid), 64'd0);
    chk("ss_cnt", 64'(pkt_count), 64'd1);

    // Backpressure, toggling tready during a 3-beat packet
    b0 = beats_seen;
    load_pkt(0, 1, 3);
    refresh();
    #1;
    for (int c = 0; c < 12; c++) begin
      m_tready = ~m_tready;
      step();
    end
    m_tready = 1'b1;
    wait_drain(20);
    chk("bp_beats", 64'(beats_seen - b0), 64'd3);
    chk("bp_cnt", 64'(pkt_count), 64'd2);

    // Round robin, two 2-beat packets per stream
    do_reset(2, 1'b0);
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 2; p++)
        load_pkt(s, p + 2, 2);
    refresh();
    #1;
    s0 = starts.size();
    repeat (11) step();
    chk("rr_cnt_c11", 64'(pkt_count), 64'd3);
    step();
    chk("rr_cnt_c12", 64'(pkt_count), 64'd4);
    wait_drain(60);
    chk("rr_starts", 64'(starts.size() - s0), 64'd8);
    for (int i = 0; i < 5; i++)
      chk("rr_order", 64'(starts[s0 + i]), 64'(rr_exp[i]));
    chk("rr_total", 64'(pkt_count), 64'd8);

    // Mask 1010, then clear bit 1 mid-packet
    mask       = 4'b1010;
    model_mask = 4'b1010;
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 2; p++)
        load_pkt(s, p + 4, 3);
    refresh();
    #1;
    s0 = starts.size();
    repeat (11) step();
    mask       = 4'b1000;
    model_mask = 4'b1000;
    #1;
    chk("mask_keep_grant", 64'(s_tready[1]), 64'd1);
    repeat (9) step();
    chk("mask_idle_v", 64'(m_tvalid), 64'd0);
    chk("mask_idle_r", 64'(s_tready), 64'd0);
    chk("mask_cnt", 64'(pkt_count), 64'd12);
    mask       = 4'hF;
    model_mask = 4'hF;
    wait_drain(80);
    chk("mask_starts", 64'(starts.size() - s0), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("mask_order", 64'(starts[s0 + i]), 64'(mk_exp[i]));
    chk("mask_total", 64'(pkt_count), 64'd16);

    // Reset after two beats of a 4-beat packet
    load_pkt(2, 6, 4);
    refresh();
    #1;
    repeat (3) step();
    do_reset(2, 1'b0);
    chk("mr_cnt", 64'(pkt_count), 64'd0);
    s0 = starts.size();
    load_pkt(2, 7, 2);
    load_pkt(0, 7, 2);
    refresh();
    #1;
    wait_drain(40);
    chk("mr_starts", 64'(starts.size() - s0), 64'd2);
    chk("mr_first", 64'(starts[s0]), 64'd0);
    chk("mr_second", 64'(starts[s0 + 1]), 64'd2);
    chk("mr_total", 64'(pkt_count), 64'd2);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
